// File: rtl/systolic_sequencer_pkg.sv
// Shared types and sizing for the systolic array sequencer.
package systolic_sequencer_pkg;

  localparam int VEC_LEN_DEF    = 4;
  localparam int ELEM_BYTES_DEF = 2;
  localparam int ACC_BYTES_DEF  = 4;

  function automatic int load_bytes(input int vec_len, input int elem_bytes);
    return 2 * vec_len * elem_bytes;
  endfunction

  function automatic int drain_bytes(input int vec_len, input int acc_bytes);
    return vec_len * vec_len * acc_bytes;
  endfunction

  localparam int LOAD_BYTES  = load_bytes(VEC_LEN_DEF, ELEM_BYTES_DEF);
  localparam int DRAIN_BYTES = drain_bytes(VEC_LEN_DEF, ACC_BYTES_DEF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SWAP    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } eng_state_t;

endpackage

// File: rtl/systolic_sequencer_load_ctr.sv
// Input byte counter for the A/B load buffers; raises full after a whole block.
module systolic_load_ctr
  import systolic_sequencer_pkg::*;
#(
  parameter int N_BYTES = LOAD_BYTES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  input  logic       swap,
  input  logic       draining,
  output logic       in_ready,
  output logic       ld_we,
  output logic       ld_sel,
  output logic [1:0] ld_idx,
  output logic       ld_hi,
  output logic       full
);

  logic [3:0] cnt;
  logic       armed;

  // The swap cycle frees the input buffer, so the first byte of the next
  // block may land in the same cycle the old contents are copied out.
  assign in_ready = ena && armed && !draining && (!full || swap);
  assign ld_we    = in_valid && in_ready;
  assign ld_sel   = cnt[3];
  assign ld_idx   = cnt[2:1];
  assign ld_hi    = armed && !cnt[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 4'd0;
      full  <= 1'b0;
      armed <= 1'b0;
    end else if (ena) begin
      armed <= 1'b1;
      if (swap) begin
        full <= 1'b0;
        cnt  <= ld_we ? 4'd1 : 4'd0;
      end else if (ld_we) begin
        if (cnt == 4'(N_BYTES - 1)) begin
          full <= 1'b1;
          cnt  <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequencer for a 4x4 BF16 systolic MAC block: load, swap, compute, drain.
//   state   | meaning
//   IDLE    | waiting for a full input block or a readout request
//   SWAP    | one cycle copying input buffers into the working A/B
//   COMPUTE | 16 MAC cycles over c[i][j]
//   DRAIN   | stream 64 accumulator bytes to the consumer
module systolic_sequencer
  import systolic_sequencer_pkg::*;
#(
  parameter int VEC_LEN    = VEC_LEN_DEF,
  parameter int ELEM_BYTES = ELEM_BYTES_DEF,
  parameter int ACC_BYTES  = ACC_BYTES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       run_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ld_we,
  output logic       ld_sel,
  output logic [1:0] ld_idx,
  output logic       ld_hi,
  output logic       swap,
  output logic       mac_en,
  output logic [3:0] mac_idx,
  output logic [3:0] out_sel,
  output logic [1:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int LOAD_N  = load_bytes(VEC_LEN, ELEM_BYTES);
  localparam int MAC_N   = VEC_LEN * VEC_LEN;
  localparam int DRAIN_N = drain_bytes(VEC_LEN, ACC_BYTES);

  eng_state_t state;
  logic [3:0] mac_cnt;
  logic [5:0] out_cnt;
  logic       pend;
  logic       full;

  systolic_load_ctr #(.N_BYTES(LOAD_N)) u_load (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .in_valid (in_valid),
    .swap     (swap),
    .draining (state == ST_DRAIN),
    .in_ready (in_ready),
    .ld_we    (ld_we),
    .ld_sel   (ld_sel),
    .ld_idx   (ld_idx),
    .ld_hi    (ld_hi),
    .full     (full)
  );

  assign swap      = ena && (state == ST_SWAP);
  assign mac_en    = ena && (state == ST_COMPUTE);
  assign out_valid = ena && (state == ST_DRAIN);
  assign mac_idx   = mac_cnt;
  assign out_sel   = out_cnt[5:2];
  assign out_byte  = out_cnt[1:0];
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      mac_cnt <= 4'd0;
      out_cnt <= 6'd0;
      pend    <= 1'b0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (run_n)     state <= ST_DRAIN;
          else if (full) state <= ST_SWAP;
        end
        ST_SWAP: begin
          if (run_n) pend <= 1'b1;
          state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (mac_cnt == 4'(MAC_N - 1)) begin
            mac_cnt <= 4'd0;
            pend    <= 1'b0;
            // A readout request outranks chaining straight into the next block.
            if (pend || run_n) state <= ST_DRAIN;
            else if (full)     state <= ST_SWAP;
            else               state <= ST_IDLE;
          end else begin
            mac_cnt <= mac_cnt + 4'd1;
            if (run_n) pend <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (out_cnt == 6'(DRAIN_N - 1)) begin
              out_cnt <= 6'd0;
              state   <= ST_IDLE;
            end else begin
              out_cnt <= out_cnt + 6'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench for systolic_sequencer: vector table, corner sequences, random scoreboard.
`timescale 1ns/1ps
module tb_systolic_sequencer;
  import systolic_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic run_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, ld_we, ld_sel, ld_hi, swap, mac_en, out_valid, busy;
  logic [1:0] ld_idx, out_byte;
  logic [3:0] mac_idx, out_sel;
  logic [3:0] ld_now;
  logic [5:0] out_now;
  logic [19:0] all_out;

  int errors = 0;
  int checks = 0;

  int loaded, swaps, macs, mac_pos, dpos;

  always #5 clk = ~clk;

  assign ld_now  = {ld_sel, ld_idx, ld_hi};
  assign out_now = {out_sel, out_byte};
  assign all_out = {in_ready, ld_we, ld_sel, ld_idx, ld_hi, swap, mac_en, mac_idx,
                    out_sel, out_byte, out_valid, busy};

  systolic_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .run_n(run_n), .in_valid(in_valid),
    .in_ready(in_ready), .ld_we(ld_we), .ld_sel(ld_sel), .ld_idx(ld_idx),
    .ld_hi(ld_hi), .swap(swap), .mac_en(mac_en), .mac_idx(mac_idx),
    .out_sel(out_sel), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  typedef struct {
    logic in_valid;
    logic e_we;
    int   e_ld;
    logic e_rdy;
    logic e_swap;
    logic e_mac;
    int   e_idx;
    logic e_busy;
  } vec_t;

  vec_t tbl[35];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected {sel, idx, hi} of the k-th byte: A0hi,A0lo,...,A3lo,B0hi,...,B3lo.
  function automatic int ld_code(input int k);
    int b;
    b = k % LOAD_BYTES;
    return ((b / (LOAD_BYTES / 2)) << 3) | (((b % (LOAD_BYTES / 2)) / 2) << 1)
           | ((b % 2 == 0) ? 1 : 0);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; run_n = 1'b0; out_ready = 1'b0; ena = 1'b1;
    #1;
    chk("reset.outputs", all_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.in_ready_before_edge", in_ready, 0);
  endtask

  task automatic load_block();
    for (int k = 0; k < LOAD_BYTES; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
    end
  endtask

  task automatic wait_mac(input int idx, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      #1;
      if (mac_en && mac_idx == 4'(idx)) ok = 1'b1;
    end
    chk($sformatf("wait_mac_idx%0d", idx), ok, 1);
  endtask

  task automatic sb_cycle();
    if (!ena) begin
      chk("rnd.ena0_strobes", {ld_we, swap, mac_en, out_valid}, 0);
    end else begin
      if (ld_we) chk("rnd.ld_order", ld_now, ld_code(loaded));
      if (swap) begin
        chk("rnd.swap_block_ready", loaded / LOAD_BYTES - swaps, 1);
        chk("rnd.swap_mac_aligned", mac_pos, 0);
        swaps++;
      end
      if (mac_en) begin
        chk("rnd.mac_idx", mac_idx, mac_pos);
        mac_pos = (mac_pos + 1) % 16;
        macs++;
      end
      if (out_valid) begin
        chk("rnd.drain_in_ready", in_ready, 0);
        if (out_ready) begin
          chk("rnd.drain_idx", out_now, dpos);
          dpos = (dpos + 1) % DRAIN_BYTES;
        end
      end
      if (ld_we) loaded++;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc;
    bit ok;

    // Vector table: reset then one block with in_valid held for 16 bytes.
    for (int s = 0; s < 35; s++) begin
      if (s < 16)       tbl[s] = '{1'b1, 1'b1, ld_code(s), 1'b1, 1'b0, 1'b0, 0, 1'b0};
      else if (s == 16) tbl[s] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
      else if (s == 17) tbl[s] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b1};
      else if (s < 34)  tbl[s] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, s - 18, 1'b1};
      else              tbl[s] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    end

    do_reset();
    for (int s = 0; s < 35; s++) begin
      @(negedge clk);
      in_valid = tbl[s].in_valid;
      #1;
      chk($sformatf("vec%0d.ld_we", s), ld_we, tbl[s].e_we);
      if (tbl[s].e_we) chk($sformatf("vec%0d.ld_addr", s), ld_now, tbl[s].e_ld);
      chk($sformatf("vec%0d.in_ready", s), in_ready, tbl[s].e_rdy);
      chk($sformatf("vec%0d.swap", s), swap, tbl[s].e_swap);
      chk($sformatf("vec%0d.mac_en", s), mac_en, tbl[s].e_mac);
      if (tbl[s].e_mac) chk($sformatf("vec%0d.mac_idx", s), mac_idx, tbl[s].e_idx);
      chk($sformatf("vec%0d.busy", s), busy, tbl[s].e_busy);
    end

    // Back-to-back blocks: next swap directly after mac_idx 15.
    do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    for (int blk = 0; blk < 2; blk++) begin
      wait_mac(15, 80);
      @(negedge clk);
      #1;
      chk($sformatf("b2b%0d.swap_after_15", blk), swap, 1);
      chk($sformatf("b2b%0d.busy", blk), busy, 1);
    end

    // Readout requested mid-compute, drained with out_ready toggling.
    do_reset();
    load_block();
    @(negedge clk);
    in_valid = 1'b0;
    wait_mac(5, 20);
    run_n = 1'b1;
    for (int m = 6; m < 16; m++) begin
      @(negedge clk);
      run_n = 1'b0;
      #1;
      chk($sformatf("pend.mac_idx%0d", m), mac_en ? int'(mac_idx) : -1, m);
    end
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) ok = 1'b1;
    end
    chk("drain.start", ok, 1);
    n = 1;
    acc = 0;
    while (ok && acc < DRAIN_BYTES && n < 300) begin
      @(negedge clk);
      out_ready = n[0];
      #1;
      chk("drain.out_valid", out_valid, 1);
      chk("drain.in_ready", in_ready, 0);
      if (out_ready) begin
        chk("drain.index", out_now, acc);
        acc++;
      end
      n++;
    end
    chk("drain.cycles", n, 128);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("drain.idle_after", {busy, out_valid}, 0);

    // Asynchronous reset in the middle of COMPUTE.
    do_reset();
    load_block();
    @(negedge clk);
    in_valid = 1'b0;
    wait_mac(7, 20);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("midrst.outputs", all_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst.in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    chk("midrst.ld_we", ld_we, 1);
    chk("midrst.ld_addr0", ld_now, ld_code(0));
    chk("midrst.busy", busy, 0);

    // ena low for 5 cycles mid-load.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ena = 1'b0;
      #1;
      chk($sformatf("ena0.ld_we%0d", k), ld_we, 0);
    end
    @(negedge clk);
    ena = 1'b1;
    #1;
    chk("ena1.ld_we", ld_we, 1);
    chk("ena1.ld_addr5", ld_now, ld_code(5));

    // Randomized traffic against the scoreboard.
    do_reset();
    loaded = 0; swaps = 0; macs = 0; mac_pos = 0; dpos = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      ena       = ($urandom_range(0, 9) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1);
      run_n     = ($urandom_range(0, 59) == 0);
      #1;
      sb_cycle();
    end
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ena = 1'b1; in_valid = 1'b0; run_n = 1'b0; out_ready = 1'b1;
      #1;
      sb_cycle();
      if (!busy && in_ready) ok = 1'b1;
    end
    chk("rnd.settled", ok, 1);
    chk("rnd.mac_total", macs, 16 * swaps);
    chk("rnd.drain_complete", dpos, 0);
    chk("rnd.some_swaps", swaps > 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
